// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, single-entry buffer to decode.
// Optional IF_MISALIGN_CHECK_EN turns a misaligned PC into a faulting NOP instead of a request.
module if_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_now,
    output logic            pc_reg_en,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic            id_fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        FULL
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            misalign;
    logic            req_hs;
    logic            id_hs;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] pc_q;

`ifdef IF_MISALIGN_CHECK_EN
    assign misalign = (pc_now[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign imem_req_valid = !rst && (state == REQ) && !misalign;
    assign imem_req_addr  = pc_now;
    assign req_hs         = imem_req_valid && imem_req_ready;

    // No decode handshake may coincide with a flush, so pc_reg_en pulses once.
    assign id_valid  = !rst && (state == FULL) && !flush;
    assign id_hs     = id_valid && id_ready;
    assign pc_reg_en = !rst && (id_hs || flush);

    assign id_inst = inst_q;
    assign id_pc   = pc_q;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!flush) state_nx = REQ;
            end
            REQ: begin
                if (misalign) state_nx = flush ? IDLE : FULL;
                else if (req_hs) state_nx = flush ? DRAIN : WAIT;
                else if (flush) state_nx = IDLE;
            end
            WAIT: begin
                if (imem_resp_valid) state_nx = flush ? IDLE : FULL;
                else if (flush) state_nx = DRAIN;
            end
            DRAIN: begin
                if (imem_resp_valid) state_nx = IDLE;
            end
            FULL: begin
                if (flush) state_nx = IDLE;
                else if (id_hs) state_nx = REQ;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            inst_q <= NOP;
            pc_q   <= '0;
        end else begin
            state <= state_nx;
            if (req_hs) pc_q <= pc_now;
            if ((state == WAIT) && imem_resp_valid && !flush) begin
                inst_q <= imem_resp_data;
            end
            if ((state == REQ) && misalign && !flush) begin
                pc_q   <= pc_now;
                inst_q <= NOP;
            end
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if ((state == REQ) && misalign && !flush) begin
            fault_q <= 1'b1;
        end else if ((state == FULL) && (state_nx != FULL)) begin
            fault_q <= 1'b0;
        end
    end

    assign id_fault = fault_q;
`else
    assign id_fault = 1'b0;
`endif

endmodule
